axi_wr_tlp_gen: RTL and testbench

- Converts AXI4 write bursts (AW + W channels) into PCIe Memory Write TLPs: one header plus a payload buffer of up to CHUNK_MAX_BEATS beats.
- Generalises the fixed 4-beat converter:
  - arbitrary awlen (1..256 beats);
  - bursts split into multiple TLPs of at most CHUNK_MAX_BEATS beats;
  - parametrised data width;
  - backpressure on the TLP output.
- Sits between the AXI slave interface of the DMA/host bridge and the TLP transmit arbiter.

---
 rtl/pcie_pkg.sv | 36 +++
 rtl/axi_wr_tlp_gen_chunk_buffer.sv | 23 ++
 rtl/axi_wr_tlp_gen.sv | 120 ++++++++++++
 tb/tb_axi_wr_tlp_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_pkg.sv
// pcie_pkg: MemWr TLP header type, format/type constants and the header builder.
// With TLP_ADDR64_EN defined, chunks above 4 GB get a 4DW header.
package pcie_pkg;
  localparam logic [2:0] FMT_MEMWR_3DW = 3'b010;
  localparam logic [2:0] FMT_MEMWR_4DW = 3'b011;
  localparam logic [4:0] TYPE_MEM = 5'b00000;
  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] tlp_type;
    logic [13:0] attrs;
    logic [9:0] length;
    logic [15:0] requester_id;
    logic [7:0] tag;
    logic [3:0] last_be;
    logic [3:0] first_be;
    logic [61:0] address;
    logic [1:0] ph;
  } tlp_memory_req_header;
  function automatic tlp_memory_req_header create_header(input logic [63:0] addr, input logic [31:0] beats,
                                                         input logic [15:0] bdf, input logic [31:0] dw_per_beat);
    create_header = '0;
`ifdef TLP_ADDR64_EN
    create_header.fmt = addr[63:32] != 32'd0 ? FMT_MEMWR_4DW : FMT_MEMWR_3DW;
    create_header.address = addr[63:2];
`else
    create_header.fmt = FMT_MEMWR_3DW;
    create_header.address = {32'd0, addr[31:2]};
`endif
    create_header.tlp_type = TYPE_MEM;
    // a 1024 DW payload wraps to 0 in the 10-bit field
    create_header.length = 10'(beats * dw_per_beat);
    create_header.requester_id = bdf;
    create_header.last_be = beats * dw_per_beat == 32'd1 ? 4'h0 : 4'hF;
    create_header.first_be = 4'hF;
  endfunction
endpackage

// File: rtl/axi_wr_tlp_gen_chunk_buffer.sv
// tlp_chunk_buffer: BEATS x DATA_WIDTH payload registers; slot 0 reads out at the MSB end.
module tlp_chunk_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int BEATS = 4,
  localparam int SW = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic we,
  input logic [SW-1:0] slot,
  input logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH*BEATS-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [BEATS];
  always_ff @(posedge clk)
    for (int i = 0; i < BEATS; i++)
      if (rst || clr) mem[i] <= '0;
      else if (we && slot == SW'(i)) mem[i] <= wdata;
  for (genvar g = 0; g < BEATS; g++) begin : g_rd
    assign rdata[(BEATS-1-g)*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end
endmodule

// File: rtl/axi_wr_tlp_gen.sv
// axi_wr_tlp_gen: splits AXI4 write bursts into PCIe MemWr TLPs of up to CHUNK_MAX_BEATS beats.
// Define TLP_ADDR64_EN for 64-bit addressing with 4DW headers above 4 GB.
module axi_wr_tlp_gen
  import pcie_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int ADDR_WIDTH = 32,
`ifdef TLP_ADDR64_EN
  localparam int AW = 64,
`else
  localparam int AW = ADDR_WIDTH,
`endif
  localparam int BW = $clog2(CHUNK_MAX_BEATS) + 1
) (
  input logic clk,
  input logic rst,
  input logic awvalid_in,
  output logic awready_out,
  input logic [3:0] awid_in,
  input logic [AW-1:0] awaddr_in,
  input logic [7:0] awlen_in,
  input logic [2:0] awsize_in,
  input logic [1:0] awburst_in,
  input logic wvalid_in,
  output logic wready_out,
  input logic [DATA_WIDTH-1:0] wdata_in,
  input logic wlast_in,
  input logic [15:0] bdf_in,
  output tlp_memory_req_header tlp_hdr_out,
  output logic [DATA_WIDTH*CHUNK_MAX_BEATS-1:0] tlp_payload_out,
  output logic [BW-1:0] tlp_beats_out,
  output logic tlp_valid,
  input logic tlp_ready,
  output logic err_out
);
  localparam int SW = CHUNK_MAX_BEATS > 1 ? $clog2(CHUNK_MAX_BEATS) : 1;
  localparam int BSH = $clog2(DATA_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  state_t state;
  logic [AW-1:0] addr;
  logic [8:0] remaining;
  logic [BW-1:0] beat_cnt;
  logic [15:0] bdf;
  logic [3:0] id;
  logic aw_hs, w_hs, tlp_hs, clr;
  logic [BW-1:0] cnt_n;
  logic [8:0] rem_n;
  assign aw_hs = state == IDLE && awvalid_in && awready_out;
  assign w_hs = state == COLLECT && wvalid_in && wready_out;
  assign tlp_hs = state == EMIT && tlp_valid && tlp_ready;
  assign clr = aw_hs || (tlp_hs && remaining != 9'd0);
  assign cnt_n = beat_cnt + BW'(1);
  assign rem_n = remaining - 9'd1;
  tlp_chunk_buffer #(.DATA_WIDTH(DATA_WIDTH), .BEATS(CHUNK_MAX_BEATS)) u_buf (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .we(w_hs),
    .slot(beat_cnt[SW-1:0]),
    .wdata(wdata_in),
    .rdata(tlp_payload_out)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      awready_out <= 1'b0;
      wready_out <= 1'b0;
      tlp_valid <= 1'b0;
      err_out <= 1'b0;
      addr <= '0;
      remaining <= '0;
      beat_cnt <= '0;
      bdf <= '0;
      id <= '0;
      tlp_hdr_out <= '0;
      tlp_beats_out <= '0;
    end else
      case (state)
        IDLE:
          if (aw_hs) begin
            addr <= awaddr_in;
            remaining <= {1'b0, awlen_in} + 9'd1;
            bdf <= bdf_in;
            id <= awid_in;
            beat_cnt <= '0;
            awready_out <= 1'b0;
            wready_out <= 1'b1;
            state <= COLLECT;
            // unsupported size/burst is flagged but still handled as full-width INCR
            if (awsize_in != 3'(BSH) || awburst_in != 2'b01) err_out <= 1'b1;
          end else awready_out <= 1'b1;
        COLLECT:
          if (w_hs) begin
            beat_cnt <= cnt_n;
            remaining <= wlast_in ? 9'd0 : rem_n;
            if (wlast_in != (remaining == 9'd1)) err_out <= 1'b1;
            if (wlast_in || rem_n == 9'd0 || cnt_n == BW'(CHUNK_MAX_BEATS)) begin
              tlp_hdr_out <= create_header(64'(addr), 32'(cnt_n), bdf, 32'(DATA_WIDTH / 32));
              tlp_beats_out <= cnt_n;
              tlp_valid <= 1'b1;
              wready_out <= 1'b0;
              state <= EMIT;
            end
          end
        default:
          if (tlp_hs) begin
            tlp_valid <= 1'b0;
            beat_cnt <= '0;
            if (remaining != 9'd0) begin
              addr <= addr + (AW'(tlp_beats_out) << BSH);
              wready_out <= 1'b1;
              state <= COLLECT;
            end else begin
              awready_out <= 1'b1;
              state <= IDLE;
            end
          end
      endcase
endmodule

// File: tb/tb_axi_wr_tlp_gen.sv
// tb_axi_wr_tlp_gen: random and directed bursts checked against a chunking reference model.
module tb_axi_wr_tlp_gen;
  import pcie_pkg::*;
  localparam int DW = 256, C = 4, BYTES = DW / 8, PW = DW * C;
`ifdef TLP_ADDR64_EN
  localparam int AW = 64;
`else
  localparam int AW = 32;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic awvalid_in = 1'b0, awready_out;
  logic [3:0] awid_in = '0;
  logic [AW-1:0] awaddr_in = '0;
  logic [7:0] awlen_in = '0;
  logic [2:0] awsize_in = '0;
  logic [1:0] awburst_in = '0;
  logic wvalid_in = 1'b0, wready_out, wlast_in = 1'b0;
  logic [DW-1:0] wdata_in = '0;
  logic [15:0] bdf_in = '0;
  tlp_memory_req_header tlp_hdr_out;
  logic [PW-1:0] tlp_payload_out;
  logic [$clog2(C):0] tlp_beats_out;
  logic tlp_valid, tlp_ready = 1'b0, err_out;
  int checks = 0, errors = 0, cyc = 0, hs_cyc = 0, valid_cyc = 0;
  logic err_exp = 1'b0;
  typedef struct {
    logic [63:0] a;
    int beats;
    logic [PW-1:0] p;
  } tlp_t;
  tlp_t exp_q[$];

  axi_wr_tlp_gen dut (
    .clk(clk), .rst(rst),
    .awvalid_in(awvalid_in), .awready_out(awready_out), .awid_in(awid_in), .awaddr_in(awaddr_in),
    .awlen_in(awlen_in), .awsize_in(awsize_in), .awburst_in(awburst_in),
    .wvalid_in(wvalid_in), .wready_out(wready_out), .wdata_in(wdata_in), .wlast_in(wlast_in),
    .bdf_in(bdf_in), .tlp_hdr_out(tlp_hdr_out), .tlp_payload_out(tlp_payload_out),
    .tlp_beats_out(tlp_beats_out), .tlp_valid(tlp_valid), .tlp_ready(tlp_ready), .err_out(err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] x;
    for (int w = 0; w < DW / 32; w++) x[w*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic check_tlp(input tlp_t e, input logic [15:0] bdf);
    int len;
    len = e.beats * DW / 32;
    check("fmt", tlp_hdr_out.fmt, e.a[63:32] != 0 ? 3'b011 : 3'b010);
    check("type", tlp_hdr_out.tlp_type, 5'b00000);
    check("length", tlp_hdr_out.length, len % 1024);
    check("address", tlp_hdr_out.address, e.a >> 2);
    check("req_id", tlp_hdr_out.requester_id, bdf);
    check("first_be", tlp_hdr_out.first_be, 4'hF);
    check("last_be", tlp_hdr_out.last_be, len == 1 ? 4'h0 : 4'hF);
    check("beats", tlp_beats_out, e.beats);
    for (int j = 0; j < C; j++)
      check("payload", tlp_payload_out[(C-1-j)*DW +: DW], e.p[(C-1-j)*DW +: DW]);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_awready"}, awready_out, 0);
    check({tag, "_wready"}, wready_out, 0);
    check({tag, "_tlp_valid"}, tlp_valid, 0);
    check({tag, "_err"}, err_out, 0);
    check({tag, "_beats"}, tlp_beats_out, 0);
    check({tag, "_hdr"}, tlp_hdr_out, 0);
    check({tag, "_payload_zero"}, tlp_payload_out == '0, 1);
  endtask

  task automatic do_aw(input logic [63:0] addr, input int awlen, input logic [15:0] bdf, input bit bad);
    int t = 0;
    awaddr_in = AW'(addr);
    awlen_in = 8'(awlen);
    awid_in = 4'($urandom);
    bdf_in = bdf;
    awsize_in = bad && $urandom_range(0, 1) == 1 ? 3'd4 : 3'd5;
    awburst_in = bad && awsize_in == 3'd5 ? 2'b00 : 2'b01;
    awvalid_in = 1'b1;
    #1;
    while (!awready_out && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("aw_timeout", t < 200, 1);
    @(negedge clk);
    awvalid_in = 1'b0;
    bdf_in = 16'($urandom);
  endtask

  // rmode: 0 random tlp_ready, 1 ready always high, 2 hold ready low 20 cycles on the first TLP
  task automatic run_burst(input logic [63:0] addr, input int awlen, input logic [15:0] bdf,
                           input int wl_idx, input bit bad, input int rmode);
    int n, total, nexp;
    logic [DW-1:0] d[$];
    n = awlen + 1;
    total = (wl_idx >= 0 && wl_idx < n) ? wl_idx + 1 : n;
    err_exp = err_exp | bad | (wl_idx != n - 1);
    if (AW == 32) addr[63:32] = '0;
    for (int i = 0; i < total; i++) d.push_back(rnd_beat());
    for (int off = 0; off < total; off += C) begin
      tlp_t t;
      int b;
      b = total - off < C ? total - off : C;
      t.a = addr + 64'(off * BYTES);
      if (AW == 32) t.a[63:32] = '0;
      t.p = '0;
      for (int j = 0; j < b; j++) t.p = (t.p << DW) | PW'(d[off + j]);
      t.p = t.p << ((C - b) * DW);
      t.beats = b;
      exp_q.push_back(t);
    end
    nexp = exp_q.size();
    do_aw(addr, awlen, bdf, bad);
    fork
      begin
        int i = 0, t = 0;
        while (i < total && t < 5000) begin
          wvalid_in = rmode != 0 || $urandom_range(0, 3) != 0;
          wdata_in = d[i];
          wlast_in = i == wl_idx;
          #1;
          if (wvalid_in && wready_out) begin
            if (i == (total < C ? total : C) - 1) hs_cyc = cyc;
            i++;
          end
          @(negedge clk);
          t++;
        end
        wvalid_in = 1'b0;
        wlast_in = 1'b0;
        check("w_timeout", t < 5000, 1);
      end
      begin
        int k = 0, t = 0;
        bit held = 0;
        tlp_memory_req_header h;
        logic [PW-1:0] p;
        while (k < nexp && t < 5000) begin
          tlp_ready = rmode == 0 ? 1'($urandom_range(0, 1)) : !(rmode == 2 && !held);
          #1;
          if (tlp_valid) begin
            check("emit_awready", awready_out, 0);
            check("emit_wready", wready_out, 0);
          end
          if (tlp_valid && rmode == 2 && !held) begin
            h = tlp_hdr_out;
            p = tlp_payload_out;
            held = 1;
            repeat (20) begin
              @(negedge clk);
              #1;
              check("hold_valid", tlp_valid, 1);
              check("hold_hdr", tlp_hdr_out, h);
              check("hold_payload", tlp_payload_out == p, 1);
              check("hold_awready", awready_out, 0);
              check("hold_wready", wready_out, 0);
            end
            tlp_ready = 1'b1;
          end
          if (tlp_valid && tlp_ready) begin
            if (k == 0) valid_cyc = cyc;
            check_tlp(exp_q.pop_front(), bdf);
            k++;
          end
          @(negedge clk);
          t++;
        end
        tlp_ready = 1'b0;
        check("tlp_timeout", t < 5000, 1);
      end
    join
    exp_q.delete();
    check("err", err_out, err_exp);
    if (rmode == 1) check("latency", valid_cyc, hs_cyc + 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_check("rst");
    rst = 1'b0;
    @(negedge clk);
    check("idle_awready", awready_out, 1);
    check("idle_wready", wready_out, 0);
    run_burst(64'h1000, 3, 16'h0002, 3, 0, 1);
    run_burst(64'h2000, 9, 16'h1234, 9, 0, 1);
    run_burst(64'h3000, 0, 16'h00a5, 0, 0, 1);
    run_burst(64'h4000, 5, 16'h0bad, 5, 0, 2);
    run_burst(64'hFFFF_FFC0, 7, 16'h0101, 7, 0, 0);
`ifdef TLP_ADDR64_EN
    run_burst(64'h1_0000_0000, 3, 16'h0042, 3, 0, 1);
    run_burst(64'h3000, 3, 16'h0043, 3, 0, 1);
`endif
    for (int r = 0; r < 25; r++) begin
      int len;
      logic [63:0] a;
      len = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 12);
      a = {$urandom_range(0, 1) == 1 ? 32'($urandom) : 32'd0, 32'($urandom)};
      run_burst(a, len, 16'($urandom), len, 0, 0);
    end
    run_burst(64'h6000, 3, 16'h0007, 1, 0, 1);
    check("err_sticky", err_out, 1);
    run_burst(64'h7000, 3, 16'h0008, 3, 0, 1);
    do_aw(64'h5000, 7, 16'h0009, 0);
    wvalid_in = 1'b1;
    wdata_in = rnd_beat();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_check("midrst");
    rst = 1'b0;
    wvalid_in = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    run_burst(64'h8000, 4, 16'h000a, 4, 0, 1);
    for (int r = 0; r < 15; r++) begin
      int len, k, wl;
      len = $urandom_range(0, 20);
      k = $urandom_range(0, 3);
      wl = (k == 1 && len > 0) ? $urandom_range(0, len - 1) : (k == 2 ? -1 : len);
      run_burst(64'($urandom), len, 16'($urandom), wl, k == 3, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
